// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial input plus the byte-delivery outputs.
// slave = receiver (uart_rx), master = whatever drives rxd and consumes bytes.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  modport master (output rxd, input rx_data, rx_done, rx_busy, frame_err, parity_err);
  modport slave  (input rxd, output rx_data, rx_done, rx_busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined).
// Delivery is push-only: rx_done is a one-clk valid strobe with no ready; rx_data/flags hold until the next strobe.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  uart_rx_if.slave   rx,
  output logic [2:0] dbg_state
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] MID_SAMP  = 4'd7;
  localparam logic [3:0] LAST_SAMP = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_ST} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             rxd_meta_q, rxd_s_q;
  logic             tick;

  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

`ifdef UART_RX_PARITY_EN
  logic pbit_q, pbit_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    if (tick && state_q != IDLE && state_q != BRK_ST) samp_d = samp_q + 4'd1;
    case (state_q)
      IDLE: if (!rxd_s_q) begin
        samp_d  = 4'd0;
        state_d = START;
      end
      START: if (tick && samp_q == MID_SAMP) begin
        if (!rxd_s_q) begin
          samp_d  = 4'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (tick && samp_q == LAST_SAMP) begin
        shift_d = {rxd_s_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick && samp_q == LAST_SAMP) begin
        pbit_d  = rxd_s_q;
        state_d = STOP;
      end
`endif
      // Outputs are registered, so they appear the clk after the stop-bit sample.
      STOP: if (tick && samp_q == LAST_SAMP) begin
        data_d  = shift_q;
        ferr_d  = ~rxd_s_q;
        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d  = (^shift_q) ^ pbit_q;
`endif
        state_d = rxd_s_q ? IDLE : BRK_ST;
      end
      BRK_ST: if (rxd_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= IDLE;
      div_q      <= '0;
      samp_q     <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q     <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= rx.rxd;
      rxd_s_q    <= rxd_meta_q;
      state_q    <= state_d;
      div_q      <= div_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q     <= pbit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_done   = done_q;
  assign rx.rx_busy   = (state_q != IDLE);
  assign rx.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = perr_q;
`else
  assign rx.parity_err = 1'b0;
`endif
  assign dbg_state = state_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the serial link driven by top_uart's txd.
- Deserialises 8N1 frames (8 data bits, LSB first, 1 stop bit) from an asynchronous rxd line using 16x oversampling.
- Presents each received byte with a one-cycle rx_done strobe plus a framing-error flag.
- Sits beside the transmitter in the UART top for loopback and host-link use.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; fixed at 16, mid-bit point is tick 7

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
rxd  input  1  serial input; idle high; asynchronous to clk
rx_data  output  8  last received byte; held until next rx_done
rx_done  output  1  one-clk pulse when rx_data/flags update
rx_busy  output  1  high whenever FSM is not IDLE
frame_err  output  1  stop bit sampled low on last frame; updates with rx_done
parity_err  output  1  parity mismatch on last frame; constant 0 unless UART_RX_PARITY_EN

Behaviour:
- Reset (async, active-high), forced immediately:
  - rx_data=8'h00; rx_done, rx_busy, frame_err and parity_err all 0.
  - Synchroniser flops = 1; FSM = IDLE; all counters = 0.
  - Asserting reset mid-frame aborts the frame with no rx_done.
- rxd passes through a 2-flop synchroniser (rxd_s); all decisions use rxd_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*16), integer division.
  - Free-running counter 0..DIV-1; tick is high for one clk when counter == DIV-1.
- Sample counter (4-bit) and bit counter (3-bit) advance only on tick.
- FSM:
  - IDLE: when rxd_s==0, clear sample counter and go to START.
  - START: on the tick where the sample count reaches 7 (mid start bit):
    - rxd_s==0: clear sample counter, bit counter=0, go to DATA.
    - rxd_s==1: glitch; return to IDLE with no output change.
  - DATA: every 16 ticks (mid-bit):
    - shift rxd_s into bit 7 of the shift register (right shift, LSB arrives first).
    - After bit counter 7 is sampled, go to STOP (or PARITY when the feature is enabled).
  - STOP: after 16 ticks, sample the stop bit, then in the next clk:
    - rx_data <= shift register.
    - frame_err <= ~rxd_s.
    - rx_done=1 for exactly one clk.
    - If the stop bit was 1, go to IDLE. If it was 0, go to BREAK.
  - BREAK: wait until rxd_s==1, then go to IDLE; no further rx_done while low.
- Byte and frame_err are delivered even on a framing error.
- Latency: rx_done asserts about 9.5 bit times after the rxd falling edge, plus 2 clk synchroniser delay plus 1 clk.
- Back-to-back frames: a start edge is accepted in IDLE on the clk after STOP exits, so there are no lost frames at full line rate.
- Start-edge alignment uncertainty ≤ 1 tick (free-running tick); acceptable.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. PARITY state follows DATA; parity bit sampled 16 ticks after bit 7.
  - parity_err <= (^shift_reg) ^ parity_bit, updated with rx_done.
  - Then STOP as normal.
- Undefined:
  - No PARITY state; parity_err tied to 0; frame is 8N1.

Test Plan:
All scenarios use CLK_FREQ=16_000_000, BAUD_RATE=100_000, giving DIV=10 and 160 clk per bit.
- Reset then idle: reset high 20 ns, rxd=1 for 2000 clk -> all outputs 0, rx_busy 0, no rx_done.
- Byte 8'hA3 (8'b10100011) as 8N1, stop bit 1 -> a single rx_done pulse at about 1520 clk ±16 after the start edge; rx_data=8'hA3; frame_err=0; rx_busy low after.
- Glitch: rxd low for 40 clk then high -> FSM returns to IDLE, no rx_done, rx_data unchanged.
- Framing error: send 8'h55 with stop bit 0, rxd held low 500 clk further -> rx_done once, rx_data=8'h55, frame_err=1; no second rx_done until rxd returns high and a new frame is sent.
- Back-to-back: frames 8'h00, 8'hFF, 8'h3C with no idle gap -> three rx_done pulses, data in order, frame_err=0 each.
- Reset mid-frame: assert reset at bit 4 of 8'hA3, then send 8'h81 -> no rx_done for the aborted frame; next rx_done gives 8'h81. With UART_RX_PARITY_EN, 8'hA3 sent with wrong parity gives parity_err=1.
